sigfmd_ctrl: RTL
================

SIGFMD_CTRL -- requirements
Module: sigfmd_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 1, meaning significand datapath cycles per step (1..4).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request strobe, sampled only in IDLE.
REQ-005 SHALL have port fdiv  input  1  1 = divide fa_in/fb_in, 0 = multiply.
REQ-006 SHALL have port db  input  1  1 = double precision, 0 = single.
REQ-007 SHALL have ports fa_in, fb_in  input  53 each  normalized significands, hidden bit at [52].
REQ-008 SHALL have ports md_fa, md_fb  output  53 each  datapath operands.
REQ-009 SHALL have ports md_oe1  output  2, md_oe2  output  1, md_fdiv  output  1, md_db  output  1  datapath step controls.
REQ-010 SHALL have port md_fq  input  57  datapath result.
REQ-011 SHALL have ports busy  output  1, done  output  1, dbz  output  1, fq_out  output  57.

Function
REQ-012 SHALL latch fa_in, fb_in, fdiv, db on the edge where state is IDLE and start=1; busy SHALL assert the next cycle.
REQ-013 SHALL implement states IDLE, LOOKUP, MUL_D, MUL_X, QUOT, DONE.
REQ-014 Multiply: IDLE -> QUOT -> DONE; QUOT drives md_fa=fa_r, md_fb=fb_r, md_oe1=2'b11, md_oe2=0.
REQ-015 Divide: IDLE -> LOOKUP -> (MUL_D -> MUL_X) x N -> QUOT -> DONE, N=3 when db=0, N=4 when db=1.
REQ-016 LOOKUP (1 cycle) SHALL load x from a 16-entry reciprocal seed table indexed by fb_r[51:48], seed in x[52:45], x[44:0]=0.
REQ-017 MUL_D SHALL drive md_fa=x, md_fb=fb_r, md_oe1=2'b01, md_oe2=1 and capture t=md_fq[56:4] (datapath returns 2-b*x).
REQ-018 MUL_X SHALL drive md_fa=x, md_fb=t, md_oe1=2'b01, md_oe2=0 and capture x=md_fq[56:4].
REQ-019 Divide QUOT SHALL drive md_fa=fa_r, md_fb=x, md_oe1=2'b11, md_oe2=0.
REQ-020 Each of MUL_D, MUL_X, QUOT SHALL last exactly MUL_LAT cycles (step counter), holding operands stable; capture on the last cycle.
REQ-021 md_fdiv/md_db SHALL equal the latched request throughout busy; all md_* outputs SHALL be 0 in IDLE.
REQ-022 DONE SHALL register fq_out from the QUOT capture, pulse done for exactly 1 cycle, deassert busy, then return to IDLE.
REQ-023 done SHALL occur MUL_LAT+1 cycles after the accepting edge for multiply, 7*MUL_LAT+2 (single) or 9*MUL_LAT+2 (double) for divide.
REQ-024 Divide with fb_r[52]=0 SHALL go IDLE -> DONE directly, dbz=1 and fq_out=all ones, done 1 cycle after acceptance.
REQ-025 dbz SHALL hold until the next accepted start; fq_out SHALL hold until the next DONE.
REQ-026 start while busy SHALL be ignored with no effect on latched operands.
REQ-027 start in the DONE cycle SHALL be ignored; start the following IDLE cycle SHALL be accepted (back-to-back rate).

Reset
REQ-028 reset=1 SHALL force IDLE, step/iteration counters 0, busy=0, done=0, dbz=0, fq_out=0, all md_* outputs 0.
REQ-029 reset mid-operation SHALL abandon the operation with no done pulse; reset takes priority over start in the same cycle.

Configuration
REQ-030 With SIGFMD_CTRL_ABORT_EN defined, the block SHALL add input abort (1 bit); abort=1 while busy SHALL return to IDLE next edge, no done, fq_out/dbz unchanged.
REQ-031 Without SIGFMD_CTRL_ABORT_EN, no abort port SHALL exist and operations always run to DONE.

Verification
REQ-032 MUL_LAT=1, fdiv=0, fa_in=53'h10000000000000, fb_in=53'h18000000000000, start -> done 2 cycles later, md_oe1=2'b11 during QUOT, fq_out=md_fq captured.
REQ-033 MUL_LAT=1, fdiv=1, db=0, fa_in=53'h18000000000000, fb_in=53'h10000000000000 -> md_oe2 sequence 1,0,1,0,1,0,0, done at cycle 9, fq_out=md_fq of QUOT.
REQ-034 MUL_LAT=2, fdiv=1, db=1 -> done at cycle 20, operands stable across each 2-cycle step.
REQ-035 fdiv=1, fb_in=0 -> dbz=1, fq_out=57'h1FFFFFFFFFFFFFF, done 1 cycle after acceptance, no md_* activity.
REQ-036 reset asserted in MUL_X of a divide -> next cycle busy=0, fq_out=0, no done; start 1 cycle later accepted normally.
REQ-037 start pulsed again while busy with different fa_in -> ignored; result matches first operands only.

Source files
------------

// File: rtl/sigfmd_ctrl.sv
// Significand multiply/divide sequencer: Newton-Raphson reciprocal refinement for divide.
// Optional abort input is enabled with `define SIGFMD_CTRL_ABORT_EN.
//   state    | meaning
//   S_IDLE   | waiting for start, md_* outputs quiet
//   S_LOOKUP | load reciprocal seed from table
//   S_MUL_D  | t = 2 - b*x
//   S_MUL_X  | x = x*t
//   S_QUOT   | final product a*b or a*x
//   S_DONE   | register result, pulse done on exit
module sigfmd_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef SIGFMD_CTRL_ABORT_EN
  input  logic        abort,
`endif
  input  logic        fdiv,
  input  logic        db,
  input  logic [52:0] fa_in,
  input  logic [52:0] fb_in,
  output logic [52:0] md_fa,
  output logic [52:0] md_fb,
  output logic [1:0]  md_oe1,
  output logic        md_oe2,
  output logic        md_fdiv,
  output logic        md_db,
  input  logic [56:0] md_fq,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [56:0] fq_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MUL_D, S_MUL_X, S_QUOT, S_DONE
  } state_t;

  localparam logic [1:0] STEP_LAST = 2'(MUL_LAT - 1);

  state_t      state, state_nx;
  logic [1:0]  step;
  logic [1:0]  iter;
  logic [52:0] fa_r, fb_r, x, t;
  logic [56:0] q;
  logic        fdiv_r, db_r;
  logic        step_last;
  logic        abort_hit;

`ifdef SIGFMD_CTRL_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Seed is 1/b at the midpoint of each fb[51:48] interval, x[52] weighted as 1.0.
  function automatic logic [7:0] seed_lut(input logic [3:0] idx);
    logic [7:0] s;
    case (idx)
      4'd0:  s = 8'd124;
      4'd1:  s = 8'd117;
      4'd2:  s = 8'd111;
      4'd3:  s = 8'd105;
      4'd4:  s = 8'd100;
      4'd5:  s = 8'd95;
      4'd6:  s = 8'd91;
      4'd7:  s = 8'd87;
      4'd8:  s = 8'd84;
      4'd9:  s = 8'd80;
      4'd10: s = 8'd77;
      4'd11: s = 8'd74;
      4'd12: s = 8'd72;
      4'd13: s = 8'd69;
      4'd14: s = 8'd67;
      default: s = 8'd65;
    endcase
    return s;
  endfunction

  assign step_last = (step == 2'd0);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (fdiv && !fb_in[52]) state_nx = S_DONE;
          else if (fdiv)          state_nx = S_LOOKUP;
          else                    state_nx = S_QUOT;
        end
      end
      S_LOOKUP: state_nx = S_MUL_D;
      S_MUL_D:  if (step_last) state_nx = S_MUL_X;
      S_MUL_X:  if (step_last) state_nx = (iter == 2'd0) ? S_QUOT : S_MUL_D;
      S_QUOT:   if (step_last) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort_hit) state_nx = S_IDLE;
  end

  always_comb begin
    md_fa   = '0;
    md_fb   = '0;
    md_oe1  = 2'b00;
    md_oe2  = 1'b0;
    md_fdiv = 1'b0;
    md_db   = 1'b0;
    if (state != S_IDLE) begin
      md_fdiv = fdiv_r;
      md_db   = db_r;
    end
    case (state)
      S_MUL_D: begin
        md_fa  = x;
        md_fb  = fb_r;
        md_oe1 = 2'b01;
        md_oe2 = 1'b1;
      end
      S_MUL_X: begin
        md_fa  = x;
        md_fb  = t;
        md_oe1 = 2'b01;
      end
      S_QUOT: begin
        md_fa  = fa_r;
        md_fb  = fdiv_r ? x : fb_r;
        md_oe1 = 2'b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      step   <= 2'd0;
      iter   <= 2'd0;
      fa_r   <= '0;
      fb_r   <= '0;
      fdiv_r <= 1'b0;
      db_r   <= 1'b0;
      x      <= '0;
      t      <= '0;
      q      <= '0;
      done   <= 1'b0;
      dbz    <= 1'b0;
      fq_out <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (state_nx != state)
        step <= (state_nx == S_MUL_D || state_nx == S_MUL_X || state_nx == S_QUOT) ?
                STEP_LAST : 2'd0;
      else if (step != 2'd0)
        step <= step - 2'd1;
      case (state)
        S_IDLE: begin
          if (start) begin
            fa_r   <= fa_in;
            fb_r   <= fb_in;
            fdiv_r <= fdiv;
            db_r   <= db;
            dbz    <= fdiv && !fb_in[52];
            iter   <= db ? 2'd3 : 2'd2;
          end
        end
        S_LOOKUP: x <= {seed_lut(fb_r[51:48]), 45'd0};
        S_MUL_D:  if (step_last) t <= md_fq[56:4];
        S_MUL_X: begin
          if (step_last) begin
            x <= md_fq[56:4];
            if (iter != 2'd0) iter <= iter - 2'd1;
          end
        end
        S_QUOT:   if (step_last) q <= md_fq;
        S_DONE: begin
          if (!abort_hit) begin
            done   <= 1'b1;
            fq_out <= dbz ? '1 : q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
